// File: rtl/game_pkg.sv
// Shared game constants, tile codes, coin FSM states and the LFSR step.
// Used by the coin collection controller and its BCD counter.
package game_pkg;

    localparam logic [2:0] SKY = 3'd1;
    localparam logic [2:0] TKN = 3'd4;

    localparam int BLOCK_WIDTH  = 40;
    localparam int SCREEN_WIDTH = 640;
    localparam int COLS         = SCREEN_WIDTH / BLOCK_WIDTH;

    // x^8+x^6+x^5+x^4+1 as Fibonacci taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        WAIT,
        PLACE
    } coin_state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD up-counter with a one-cycle pulse on the 99 -> 00 wrap.
// Increments once per cycle that inc is high.
module bcd_counter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [7:0] count,
    output logic       wrap
);

    // Units roll into tens; tens rolling over raises wrap for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'h00;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (inc) begin
                if (count[3:0] == 4'd9) begin
                    count[3:0] <= 4'd0;
                    if (count[7:4] == 4'd9) begin
                        count[7:4] <= 4'd0;
                        wrap       <= 1'b1;
                    end else begin
                        count[7:4] <= count[7:4] + 4'd1;
                    end
                end else begin
                    count[3:0] <= count[3:0] + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/coin_collect_ctrl.sv
// Coin collection controller: clears a touched coin, counts it in BCD,
// and after a delay respawns it at a pseudo-random tile.
module coin_collect_ctrl
    import game_pkg::*;
#(
    parameter int COIN_ROW_MIN   = 3,
    parameter int COIN_ROW_MAX   = 8,
    parameter int RESPAWN_CYCLES = 25000000,
    parameter int INIT_X         = 5,
    parameter int INIT_Y         = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        touch,
    output logic [31:0] coin_x,
    output logic [31:0] coin_y,
    output logic        coin_active,
    output logic        map_wr_req,
    output logic [31:0] map_wr_x,
    output logic [31:0] map_wr_y,
    output logic [2:0]  map_wr_tile,
    input  logic        map_wr_ack,
    output logic [7:0]  coin_count_bcd,
    output logic        lives_up
);

    localparam int XSPAN = COLS - 2;
    localparam int YSPAN = COIN_ROW_MAX - COIN_ROW_MIN + 1;

    coin_state_t state;
    logic        touch_q;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;
    logic [31:0] cnt;
    logic [31:0] new_x;
    logic [31:0] new_y;
    logic        clear_done;

    // Respawn position keeps the coin off the border columns
    always_comb begin
        lfsr_next = lfsr_step(lfsr);
        new_x = 32'd1 + (32'(lfsr_next[3:0]) % 32'(XSPAN));
        new_y = 32'(COIN_ROW_MIN)
              + (32'(lfsr_next[7:4]) % 32'(YSPAN));
        clear_done = (state == CLEAR) && map_wr_req && map_wr_ack;
    end

    bcd_counter2 u_count (
        .clk   (clk),
        .reset (reset),
        .inc   (clear_done),
        .count (coin_count_bcd),
        .wrap  (lives_up)
    );

    // Collect / clear / wait / place sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            coin_x      <= 32'(INIT_X);
            coin_y      <= 32'(INIT_Y);
            coin_active <= 1'b1;
            map_wr_req  <= 1'b0;
            map_wr_x    <= 32'd0;
            map_wr_y    <= 32'd0;
            map_wr_tile <= 3'd0;
            touch_q     <= 1'b0;
            lfsr        <= LFSR_SEED;
            cnt         <= 32'd0;
        end else begin
            touch_q <= touch;
            unique case (state)
                IDLE: begin
                    if (touch && !touch_q) begin
                        state       <= CLEAR;
                        map_wr_req  <= 1'b1;
                        map_wr_x    <= coin_x;
                        map_wr_y    <= coin_y;
                        map_wr_tile <= SKY;
                        coin_active <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (map_wr_req && map_wr_ack) begin
                        map_wr_req <= 1'b0;
                        cnt        <= 32'(RESPAWN_CYCLES - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 32'd0) begin
                        state       <= PLACE;
                        lfsr        <= lfsr_next;
                        map_wr_req  <= 1'b1;
                        map_wr_x    <= new_x;
                        map_wr_y    <= new_y;
                        map_wr_tile <= TKN;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                PLACE: begin
                    if (map_wr_req && map_wr_ack) begin
                        map_wr_req  <= 1'b0;
                        coin_x      <= map_wr_x;
                        coin_y      <= map_wr_y;
                        coin_active <= 1'b1;
                        touch_q     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_collect_ctrl.sv
// Scoreboard bench for coin_collect_ctrl: a reference model predicts map
// writes and coin/score state; a monitor compares on every negedge.
module tb_coin_collect_ctrl;

    localparam int RESP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        touch;
    logic        map_wr_ack;
    logic [31:0] coin_x;
    logic [31:0] coin_y;
    logic        coin_active;
    logic        map_wr_req;
    logic [31:0] map_wr_x;
    logic [31:0] map_wr_y;
    logic [2:0]  map_wr_tile;
    logic [7:0]  coin_count_bcd;
    logic        lives_up;

    coin_collect_ctrl #(.RESPAWN_CYCLES(RESP)) dut (
        .clk            (clk),
        .reset          (reset),
        .touch          (touch),
        .coin_x         (coin_x),
        .coin_y         (coin_y),
        .coin_active    (coin_active),
        .map_wr_req     (map_wr_req),
        .map_wr_x       (map_wr_x),
        .map_wr_y       (map_wr_y),
        .map_wr_tile    (map_wr_tile),
        .map_wr_ack     (map_wr_ack),
        .coin_count_bcd (coin_count_bcd),
        .lives_up       (lives_up)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int tile;
        bit place;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    // model state
    int  m_x, m_y, m_lfsr, m_coll, exp_bcd, gap, lives_seen;
    bit  m_active, m_ready, m_tq, exp_lives, req_due, wait_on;

    // ack driver controls
    bit  tied = 1'b1;
    int  fixed_dly = 0;
    int  dly = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int to_bcd(input int n);
        return ((n / 10) << 4) | (n % 10);
    endfunction

    function automatic int next_lfsr(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 255) | fb;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_x = 5; m_y = 6; m_lfsr = 'hA5; m_coll = 0;
        exp_bcd = 0; exp_lives = 0;
        m_active = 1; m_ready = 1; m_tq = 0;
        req_due = 0; wait_on = 0; gap = 0;
    endtask

    // Arbiter model: ack after a chosen delay, or tied high
    initial begin
        map_wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (map_wr_req) begin
                if (dly == 0) map_wr_ack = 1'b1;
                else begin
                    map_wr_ack = 1'b0;
                    dly--;
                end
            end else begin
                map_wr_ack = tied;
                dly = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 3);
            end
        end
    end

    // Reference model plus monitor
    initial begin
        wr_t w;
        bit  collect_now, placed;
        int  nx, ny;
        lives_seen = 0;
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) begin
                model_reset();
                continue;
            end
            check("coin_x", int'(coin_x), m_x);
            check("coin_y", int'(coin_y), m_y);
            check("coin_active", int'(coin_active), int'(m_active));
            check("count_bcd", int'(coin_count_bcd), exp_bcd);
            check("lives_up", int'(lives_up), int'(exp_lives));
            if (lives_up) lives_seen++;
            if (req_due) begin
                check("req_rise", int'(map_wr_req), 1);
                req_due = 0;
            end
            if (wait_on) begin
                gap++;
                if (gap <= RESP) check("wait_req_low", int'(map_wr_req), 0);
                else begin
                    check("wait_len", int'(map_wr_req), 1);
                    wait_on = 0;
                end
            end
            collect_now = m_ready && touch && !m_tq;
            placed = 0;
            exp_lives = 0;
            if (exp_q.size() == 0) begin
                check("req_idle", int'(map_wr_req), 0);
            end else if (map_wr_req) begin
                check("wr_x", int'(map_wr_x), exp_q[0].x);
                check("wr_y", int'(map_wr_y), exp_q[0].y);
                check("wr_tile", int'(map_wr_tile), exp_q[0].tile);
                if (map_wr_ack) begin
                    w = exp_q.pop_front();
                    if (!w.place) begin
                        m_coll++;
                        exp_bcd = to_bcd(m_coll % 100);
                        exp_lives = (m_coll % 100 == 0);
                        wait_on = 1;
                        gap = 0;
                    end else begin
                        m_x = w.x;
                        m_y = w.y;
                        m_active = 1;
                        m_ready = 1;
                        placed = 1;
                    end
                end
            end
            if (collect_now) begin
                exp_q.push_back('{x: m_x, y: m_y, tile: 1, place: 0});
                m_lfsr = next_lfsr(m_lfsr);
                nx = 1 + (m_lfsr % 16) % 14;
                ny = 3 + (m_lfsr / 16) % 6;
                exp_q.push_back('{x: nx, y: ny, tile: 4, place: 1});
                m_active = 0;
                m_ready = 0;
                req_due = 1;
            end
            m_tq = placed ? 1'b0 : touch;
        end
    end

    task automatic pulse_touch();
        touch = 1'b1;
        @(posedge clk); #1;
        touch = 1'b0;
    endtask

    // Stimulus
    initial begin
        int target;
        reset = 1'b1;
        touch = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // first collection with ack tied high
        repeat (7) @(posedge clk);
        #1 pulse_touch();
        repeat (15) @(posedge clk);
        #1;
        check("first_respawn_x", int'(coin_x), 11);
        check("first_respawn_y", int'(coin_y), 7);

        // touch held high across several respawns
        touch = 1'b1;
        repeat (50) @(posedge clk);
        #1 touch = 1'b0;
        repeat (20) @(posedge clk);

        // ack held off three cycles
        #1 tied = 1'b0;
        fixed_dly = 3;
        pulse_touch();
        repeat (30) @(posedge clk);

        // random touches with random ack delays
        #1 fixed_dly = -1;
        repeat (300) begin
            @(posedge clk);
            #1 touch = ($urandom_range(0, 3) == 0);
        end
        touch = 1'b0;
        repeat (40) @(posedge clk);

        // run past the next hundred-coin wrap
        #1 tied = 1'b1;
        fixed_dly = 0;
        target = (m_coll / 100 + 1) * 100 + 1;
        touch = 1'b1;
        for (int i = 0; i < 3000 && m_coll < target; i++) @(posedge clk);
        #1 touch = 1'b0;
        check("preload_reached", int'(m_coll >= target), 1);
        repeat (20) @(posedge clk);
        #1 check("lives_pulses", lives_seen, m_coll / 100);

        // reset in the middle of a held-off clear
        tied = 1'b0;
        fixed_dly = 10;
        pulse_touch();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_count", int'(coin_count_bcd), 0);
        check("post_reset_req", int'(map_wr_req), 0);

        // collection after reset replays the seeded respawn
        tied = 1'b1;
        fixed_dly = 0;
        pulse_touch();
        repeat (20) @(posedge clk);
        #1;
        check("reset_respawn_x", int'(coin_x), 11);
        check("reset_respawn_y", int'(coin_y), 7);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/coin_collect_ctrl.md
Name: coin_collect_ctrl

Overview:
- Consumer side of the coin touch detector. It takes the registered `touch` level for the active coin tile and clears that tile in the level tile map through a write handshake.
- It keeps a 2-digit BCD coin count and pulses `lives_up` on every 100th coin.
- After a fixed delay it respawns the coin at a pseudo-random tile, writes TKN there and publishes the new coin tile coordinates back to the detector.
- Sits between the coin detector and the tile-map RAM arbiter.

Parameters:
- SKY, 1, tile code written when a coin is cleared
- TKN, 4, tile code written when a coin is placed
- SCREEN_WIDTH, 640, pixels; columns = SCREEN_WIDTH/BLOCK_WIDTH (16)
- BLOCK_WIDTH, 40, tile size in pixels
- COIN_ROW_MIN, 3, lowest tile row index a respawned coin may occupy
- COIN_ROW_MAX, 8, highest tile row index a respawned coin may occupy
- RESPAWN_CYCLES, 25000000, cycles between clear-ack and placement request (min 1)
- INIT_X, 5, coin tile column after reset
- INIT_Y, 6, coin tile row after reset

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- touch  in  1  Mario overlaps current coin tile (level, from detector)
- coin_x  out  int  current coin tile column (detector input)
- coin_y  out  int  current coin tile row (detector input)
- coin_active  out  1  coin present and collectable
- map_wr_req  out  1  tile-map write request
- map_wr_x  out  int  write column
- map_wr_y  out  int  write row
- map_wr_tile  out  3  tile code to write
- map_wr_ack  in  1  arbiter accepted the write
- coin_count_bcd  out  8  [7:4] tens, [3:0] units
- lives_up  out  1  one-cycle pulse on 99->00 wrap

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high, sampled at posedge `clk`. It overrides everything, including a mid-handshake state.
- Reset values:
  - state=IDLE, coin_x=INIT_X, coin_y=INIT_Y, coin_active=1
  - map_wr_req=0, map_wr_x=0, map_wr_y=0, map_wr_tile=0
  - coin_count_bcd=8'h00, lives_up=0
  - touch_q=0, lfsr=8'hA5, respawn counter=0
  - The initial coin is already present in the map; no write is issued at reset.
- touch_q <= touch every cycle, except it is forced to 0 on the PLACE->IDLE edge. A level already high on the first IDLE cycle therefore counts as an edge.
- IDLE:
  - On touch & ~touch_q -> CLEAR next cycle.
  - In that same edge: map_wr_req=1, map_wr_x/y=coin_x/y, map_wr_tile=SKY, coin_active=0.
  - Touch edges outside IDLE are ignored.
- CLEAR:
  - Hold req, address and tile stable until map_wr_ack=1 is sampled with req=1.
  - On that edge: req=0, coin_count_bcd increments, counter loads RESPAWN_CYCLES-1, -> WAIT.
  - Ack in the same cycle req first rises is legal; ack while req=0 is ignored.
- BCD increment:
  - Units 9 -> 0 with carry into tens.
  - 99 -> 00 with lives_up=1 for exactly that following cycle; otherwise lives_up=0.
- WAIT:
  - Decrement the counter. At counter==0 -> PLACE.
  - WAIT occupies exactly RESPAWN_CYCLES cycles.
- PLACE entry:
  - LFSR advances once (Fibonacci, x^8+x^6+x^5+x^4+1, shift left, feedback = b7^b5^b4^b3 into b0).
  - new_x = 1 + (lfsr_next[3:0] mod (COLS-2)).
  - new_y = COIN_ROW_MIN + (lfsr_next[7:4] mod (COIN_ROW_MAX-COIN_ROW_MIN+1)).
  - map_wr_req=1, map_wr_x/y=new, map_wr_tile=TKN.
- PLACE:
  - Hold until ack.
  - On ack edge: req=0, coin_x/y=new, coin_active=1, -> IDLE.
  - coin_x/y stay at the old value throughout CLEAR/WAIT/PLACE.
- LFSR changes only on PLACE entry and never reaches 0.
- Minimum collect-to-collectable latency = 1 (edge) + 1 (ack) + RESPAWN_CYCLES + 1 (ack) cycles.

Decomposition:
- Shared package game_pkg:
  - tile codes SKY/TKN
  - BLOCK_WIDTH, SCREEN_WIDTH
  - coin_state_t enum {IDLE, CLEAR, WAIT, PLACE}
  - LFSR seed/taps constants
- One sub-module: bcd_counter2 (increment enable, 8-bit BCD out, wrap pulse).

Test Plan:
- Reset then touch=1 on cycle 10 with ack tied 1 -> map_wr_req=1 on cycle 11 (x=5, y=6, tile=1), count 8'h01 on cycle 12, coin_active=0.
- Hold touch=1 for 50 cycles in IDLE after the first collection is complete and respawned (RESPAWN_CYCLES=4) -> exactly one more increment per respawn, never two per edge.
- Ack delayed 3 cycles in CLEAR -> req, x, y, tile stable all 3 cycles; req drops the cycle after ack.
- Preload 99 collections (RESPAWN_CYCLES=1) -> count 8'h99 -> next collect gives 8'h00 and lives_up high exactly one cycle.
- RESPAWN_CYCLES=4 -> PLACE req exactly 4 cycles after the CLEAR ack edge. First respawn uses LFSR 8'h4A: x=1+(10 mod 14)=11, y=3+(4 mod 6)=7, tile=4. coin_x/y update on the ack edge.
- Reset asserted during CLEAR with req=1 and no ack -> next cycle req=0, count 8'h00, coin at (5,6), coin_active=1.
